// File: rtl/car_traffic_ctrl.sv
// car_traffic_ctrl: per-frame position update for the six road-lane cars.
// A rising edge on vga_vs starts a six-cycle sweep into shadow registers.
// A single commit cycle then publishes all six X positions together.
module car_traffic_ctrl #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned GRID_HEIGHT = 32,
  parameter int unsigned BASE_SPEED  = 1,
  parameter int unsigned SPACING     = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vga_vs,
  input  logic       pause,
  input  logic [2:0] level,
  output logic [9:0] carX_1,
  output logic [9:0] carX_2,
  output logic [9:0] carX_3,
  output logic [9:0] carX_4,
  output logic [9:0] carX_5,
  output logic [9:0] carX_6,
  output logic [8:0] carY_1,
  output logic [8:0] carY_2,
  output logic [8:0] carY_3,
  output logic [8:0] carY_4,
  output logic [8:0] carY_5,
  output logic [8:0] carY_6,
  output logic       frame_done,
  output logic       busy
);

  localparam int unsigned NCARS = 6;
  localparam int unsigned XW    = 10;
  localparam int unsigned YW    = 9;
  localparam int unsigned AW    = 11;
  localparam int unsigned SW    = 4;
  localparam int unsigned IW    = 3;
  localparam int unsigned LW    = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_COMMIT
  } state_e;

  state_e          state_q;
  logic            vs_q;
  logic [LW-1:0]   lvl_q;
  logic [IW-1:0]   idx_q;
  logic [XW-1:0]   shadow_q [NCARS];
  logic [XW-1:0]   car_x_q  [NCARS];
  logic            frame_done_q;
  logic            busy_q;

  logic            tick_c;
  logic [1:0]      kmod3_c;
  logic [SW-1:0]   step_c;
  logic [AW-1:0]   x_c;
  logic [AW-1:0]   sum_c;
  logic [AW-1:0]   upd_x_d;

  // End of vertical sync: vga_vs going from low to high.
  assign tick_c = vga_vs & ~vs_q;

  // Wrapped next X for the car selected by idx_q; even cars move right, odd cars left.
  always_comb begin
    kmod3_c = 2'd0;
    case (idx_q)
      3'd0, 3'd3: kmod3_c = 2'd0;
      3'd1, 3'd4: kmod3_c = 2'd1;
      default:    kmod3_c = 2'd2;
    endcase
    step_c  = SW'(BASE_SPEED) + SW'(kmod3_c) + SW'(lvl_q);
    x_c     = AW'(shadow_q[idx_q]);
    sum_c   = x_c + AW'(step_c);
    upd_x_d = x_c;
    if (!idx_q[0]) begin
      upd_x_d = (sum_c >= AW'(H_ACTIVE)) ? (sum_c - AW'(H_ACTIVE)) : sum_c;
    end else begin
      upd_x_d = (x_c < AW'(step_c)) ? (x_c + AW'(H_ACTIVE) - AW'(step_c))
                                    : (x_c - AW'(step_c));
    end
  end

  // Sweep sequencer: IDLE waits for a tick, UPDATE steps one car per cycle, COMMIT publishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vs_q         <= 1'b1;
      lvl_q        <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < int'(NCARS); i++) begin
        shadow_q[i] <= XW'(i * int'(SPACING));
        car_x_q[i]  <= XW'(i * int'(SPACING));
      end
    end else begin
      vs_q         <= vga_vs;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tick_c && !pause) begin
            lvl_q   <= level;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          shadow_q[idx_q] <= XW'(upd_x_d);
          if (idx_q == IW'(NCARS - 1)) begin
            state_q <= S_COMMIT;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_COMMIT: begin
          for (int i = 0; i < int'(NCARS); i++) begin
            car_x_q[i] <= shadow_q[i];
          end
          frame_done_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign carX_1 = car_x_q[0];
  assign carX_2 = car_x_q[1];
  assign carX_3 = car_x_q[2];
  assign carX_4 = car_x_q[3];
  assign carX_5 = car_x_q[4];
  assign carX_6 = car_x_q[5];

  // Lanes are fixed: car n sits on grid row 2*n.
  assign carY_1 = YW'(2  * GRID_HEIGHT);
  assign carY_2 = YW'(4  * GRID_HEIGHT);
  assign carY_3 = YW'(6  * GRID_HEIGHT);
  assign carY_4 = YW'(8  * GRID_HEIGHT);
  assign carY_5 = YW'(10 * GRID_HEIGHT);
  assign carY_6 = YW'(12 * GRID_HEIGHT);

  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_car_traffic_ctrl.sv
// tb_car_traffic_ctrl: randomized frames against a modular-arithmetic position model.
module tb_car_traffic_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       vga_vs;
  logic       pause;
  logic [2:0] level;
  logic [9:0] carX_1, carX_2, carX_3, carX_4, carX_5, carX_6;
  logic [8:0] carY_1, carY_2, carY_3, carY_4, carY_5, carY_6;
  logic       frame_done;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int pos [6];

  car_traffic_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .vga_vs     (vga_vs),
    .pause      (pause),
    .level      (level),
    .carX_1     (carX_1),
    .carX_2     (carX_2),
    .carX_3     (carX_3),
    .carX_4     (carX_4),
    .carX_5     (carX_5),
    .carX_6     (carX_6),
    .carY_1     (carY_1),
    .carY_2     (carY_2),
    .carY_3     (carY_3),
    .carY_4     (carY_4),
    .carY_5     (carY_5),
    .carY_6     (carY_6),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dut_x(input int k);
    case (k)
      0: return 32'(carX_1);
      1: return 32'(carX_2);
      2: return 32'(carX_3);
      3: return 32'(carX_4);
      4: return 32'(carX_5);
      default: return 32'(carX_6);
    endcase
  endfunction

  task automatic check_pos(input string tag);
    for (int k = 0; k < 6; k++) check($sformatf("%s carX_%0d", tag, k + 1), dut_x(k), pos[k]);
  endtask

  task automatic check_y();
    check("carY_1", 32'(carY_1), 64);
    check("carY_2", 32'(carY_2), 128);
    check("carY_3", 32'(carY_3), 192);
    check("carY_4", 32'(carY_4), 256);
    check("carY_5", 32'(carY_5), 320);
    check("carY_6", 32'(carY_6), 384);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 6; k++) pos[k] = k * 100;
  endtask

  // One accepted frame: even cars advance right, odd cars left, modulo the screen width.
  task automatic model_frame(input int lvl);
    for (int k = 0; k < 6; k++) begin
      int st;
      st = 1 + (k % 3) + lvl;
      if (k % 2 == 0) pos[k] = (pos[k] + st) % 640;
      else            pos[k] = (pos[k] - st + 640) % 640;
    end
  endtask

  // One vs pulse; optional second edge during the sweep and random input churn mid-sweep.
  task automatic do_frame(input int lvl, input bit pse, input bit glitch, input bit churn);
    bit acc;
    acc    = !pse;
    level  = 3'(lvl);
    pause  = pse;
    vga_vs = 1'b0;
    step();
    vga_vs = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (acc && c == 8) model_frame(lvl);
      check($sformatf("busy c%0d", c), 32'(busy), (acc && c <= 7) ? 1 : 0);
      check($sformatf("frame_done c%0d", c), 32'(frame_done), (acc && c == 8) ? 1 : 0);
      check_pos($sformatf("c%0d", c));
      if (churn && acc && c <= 6) begin
        level = 3'($urandom_range(0, 7));
        pause = 1'($urandom_range(0, 1));
      end
      if (glitch && c == 2) vga_vs = 1'b0;
      if (glitch && c == 3) vga_vs = 1'b1;
    end
    pause = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst    = 1'b1;
    vga_vs = 1'b1;
    pause  = 1'b0;
    level  = 3'd0;
    do_reset();
    check("reset busy", 32'(busy), 0);
    check("reset frame_done", 32'(frame_done), 0);
    check_pos("reset");
    check_y();

    // Level 0 single frame, absolute expectations
    do_frame(0, 1'b0, 1'b0, 1'b0);
    check("lvl0 carX_1", 32'(carX_1), 1);
    check("lvl0 carX_2", 32'(carX_2), 98);
    check("lvl0 carX_3", 32'(carX_3), 203);
    check("lvl0 carX_4", 32'(carX_4), 299);
    check("lvl0 carX_5", 32'(carX_5), 402);
    check("lvl0 carX_6", 32'(carX_6), 497);

    // Wrap boundaries at level 7
    do_reset();
    for (int f = 1; f <= 80; f++) begin
      do_frame(7, 1'b0, 1'b0, 1'b0);
      if (f == 12) check("left wrap carX_2", 32'(carX_2), 632);
    end
    check("right wrap carX_1", 32'(carX_1), 0);

    // Paused ticks are ignored
    for (int f = 0; f < 5; f++) do_frame(3, 1'b1, 1'b0, 1'b0);

    // Second edge three cycles after the first is dropped
    do_frame(2, 1'b0, 1'b1, 1'b0);

    // Reset in the third UPDATE cycle abandons the sweep
    level  = 3'd5;
    vga_vs = 1'b0;
    step();
    vga_vs = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    model_reset();
    step();
    check("abort busy", 32'(busy), 0);
    check("abort frame_done", 32'(frame_done), 0);
    check_pos("abort");
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("post-abort frame_done", 32'(frame_done), 0);
      check("post-abort busy", 32'(busy), 0);
    end
    check_pos("post-abort");

    // Randomized frames
    for (int f = 0; f < 250; f++) begin
      do_frame(int'($urandom_range(0, 7)), 1'($urandom_range(0, 4) == 0),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        for (int c = 0; c < int'($urandom_range(0, 4)); c++) step();
      end
    end
    check_y();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
